// File: rtl/uart_reg_bridge.sv
// UART byte-stream command responder: parses W/R packets, drives an
// 8-bit local register bus and answers with ACK/NAK/data bytes.
module uart_reg_bridge #(
   parameter int TIMEOUT    = 50000,
   parameter int RD_LATENCY = 1
) (
   input  logic       ipClk,
   input  logic       ipReset,
   input  logic [7:0] ipRxData,
   input  logic       ipRxValid,
   output logic [7:0] opTxData,
   output logic       opTxSend,
   input  logic       ipTxBusy,
   output logic [7:0] opAddress,
   output logic [7:0] opWrData,
   output logic       opWrEnable,
   output logic       opRdEnable,
   input  logic [7:0] ipRdData,
   output logic       opError
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int LW = $clog2(RD_LATENCY + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
   localparam logic [LW-1:0] LLAST = LW'(RD_LATENCY - 1);

   localparam logic [7:0] SYNC = 8'h55;
   localparam logic [7:0] CMDW = 8'h57;
   localparam logic [7:0] CMDR = 8'h52;
   localparam logic [7:0] ACK  = 8'h06;
   localparam logic [7:0] NAK  = 8'h15;

   typedef enum logic [3:0] {
      IDLE, GET_CMD, GET_ADDR, GET_DATA, WRITE,
      READ, RD_WAIT, TX_ACK, TX_DATA, TX_NAK
   } stateT;

   typedef enum logic [1:0] {PH_WAIT, PH_SEND, PH_DONE} phaseT;

   stateT         state, stateNext;
   phaseT         phase, phaseNext;
   logic          isWrite, isWriteNext;
   logic [7:0]    rdHold, rdHoldNext;
   logic [7:0]    addrNext, wrDataNext, txDataNext;
   logic          sendNext, errorNext;
   logic [TW-1:0] timer, timerNext;
   logic [LW-1:0] latCnt, latCntNext;
   logic          inGet, rxOk, timedOut;
   logic [7:0]    txByte;

   assign opWrEnable = (state == WRITE);
   assign opRdEnable = (state == READ);

   always_ff @(posedge ipClk) begin
      if (ipReset) begin
         state     <= IDLE;
         phase     <= PH_WAIT;
         isWrite   <= 1'b0;
         rdHold    <= '0;
         opAddress <= '0;
         opWrData  <= '0;
         opTxData  <= '0;
         opTxSend  <= 1'b0;
         opError   <= 1'b0;
         timer     <= '0;
         latCnt    <= '0;
      end else begin
         state     <= stateNext;
         phase     <= phaseNext;
         isWrite   <= isWriteNext;
         rdHold    <= rdHoldNext;
         opAddress <= addrNext;
         opWrData  <= wrDataNext;
         opTxData  <= txDataNext;
         opTxSend  <= sendNext;
         opError   <= errorNext;
         timer     <= timerNext;
         latCnt    <= latCntNext;
      end
   end

   always_comb begin
      stateNext   = state;
      phaseNext   = phase;
      isWriteNext = isWrite;
      rdHoldNext  = rdHold;
      addrNext    = opAddress;
      wrDataNext  = opWrData;
      txDataNext  = opTxData;
      sendNext    = opTxSend;
      errorNext   = 1'b0;
      latCntNext  = latCnt;
      timerNext   = '0;

      inGet = (state == GET_CMD) || (state == GET_ADDR)
           || (state == GET_DATA);
      rxOk  = inGet || (state == IDLE);
      timedOut = inGet && !ipRxValid && (timer == TLAST);

      txByte = ACK;
      if (state == TX_DATA) txByte = rdHold;
      else if (state == TX_NAK) txByte = NAK;

      if (inGet && !ipRxValid) timerNext = timer + 1'b1;

      // bytes outside the receive states are judged by the current state
      if (ipRxValid && !rxOk) errorNext = 1'b1;

      unique case (state)
         IDLE: begin
            if (ipRxValid && ipRxData == SYNC) stateNext = GET_CMD;
         end
         GET_CMD: begin
            if (ipRxValid) begin
               if (ipRxData == CMDW || ipRxData == CMDR) begin
                  isWriteNext = (ipRxData == CMDW);
                  stateNext   = GET_ADDR;
               end else begin
                  stateNext = TX_NAK;
                  errorNext = 1'b1;
               end
            end
         end
         GET_ADDR: begin
            if (ipRxValid) begin
               addrNext  = ipRxData;
               stateNext = isWrite ? GET_DATA : READ;
            end
         end
         GET_DATA: begin
            if (ipRxValid) begin
               wrDataNext = ipRxData;
               stateNext  = WRITE;
            end
         end
         WRITE: stateNext = TX_ACK;
         READ: begin
            latCntNext = '0;
            stateNext  = RD_WAIT;
         end
         RD_WAIT: begin
            if (latCnt == LLAST) begin
               rdHoldNext = ipRdData;
               stateNext  = TX_ACK;
            end else begin
               latCntNext = latCnt + 1'b1;
            end
         end
         TX_ACK, TX_DATA, TX_NAK: begin
            unique case (phase)
               PH_WAIT: begin
                  if (!ipTxBusy) begin
                     sendNext   = 1'b1;
                     txDataNext = txByte;
                     phaseNext  = PH_SEND;
                  end
               end
               PH_SEND: begin
                  if (ipTxBusy) begin
                     sendNext  = 1'b0;
                     phaseNext = PH_DONE;
                  end
               end
               PH_DONE: begin
                  if (!ipTxBusy) begin
                     phaseNext = PH_WAIT;
                     stateNext = (state == TX_ACK && !isWrite)
                               ? TX_DATA : IDLE;
                  end
               end
               default: phaseNext = PH_WAIT;
            endcase
         end
         default: stateNext = IDLE;
      endcase

      if (timedOut) begin
         stateNext = IDLE;
         errorNext = 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Two bridges (read latency 1 and 4) share one Rx stream and are scored
// against a transaction-level model: expected bus ops, Tx bytes, errors.
module tb_uart_reg_bridge;

   localparam int TOUT = 200;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst       = 1'b1;
   logic [7:0] rxData    = '0;
   logic       rxValid   = 1'b0;
   logic       forceBusy = 1'b0;
   logic       sinkLong  = 1'b0;
   logic       sinkDeaf  = 1'b0;
   logic       pktEnd    = 1'b0;
   logic       chkZero   = 1'b0;
   logic       hang      = 1'b0;

   logic [7:0] txData [2];
   logic       txSend [2];
   logic       txBusy [2];
   logic [7:0] addr   [2];
   logic [7:0] wrData [2];
   logic       wrEn   [2];
   logic       rdEn   [2];
   logic [7:0] rdData [2];
   logic       err    [2];

   logic [7:0] mem     [2][256] = '{default: '0};
   logic [3:0] vPipe   [2]      = '{default: '0};
   logic [7:0] dPipe   [2][4]   = '{default: '0};
   logic [7:0] sinkCnt [2]      = '{default: '0};

   for (genvar g = 0; g < 2; g++) begin : gDut
      localparam int LAT = (g == 0) ? 1 : 4;
      assign txBusy[g] = forceBusy || (sinkCnt[g] != 8'd0);
      assign rdData[g] = vPipe[g][LAT-1] ? dPipe[g][LAT-1]
                                         : ~dPipe[g][LAT-1];
      uart_reg_bridge #(.TIMEOUT(TOUT), .RD_LATENCY(LAT)) dut (
         .ipClk(clk), .ipReset(rst),
         .ipRxData(rxData), .ipRxValid(rxValid),
         .opTxData(txData[g]), .opTxSend(txSend[g]),
         .ipTxBusy(txBusy[g]),
         .opAddress(addr[g]), .opWrData(wrData[g]),
         .opWrEnable(wrEn[g]), .opRdEnable(rdEn[g]),
         .ipRdData(rdData[g]), .opError(err[g]));
   end

   // register-file slave and UART transmitter stand-ins
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (wrEn[k]) mem[k][addr[k]] <= wrData[k];
         vPipe[k] <= {vPipe[k][2:0], rdEn[k]};
         dPipe[k][0] <= mem[k][addr[k]];
         for (int i = 1; i < 4; i++) dPipe[k][i] <= dPipe[k][i-1];
         if (sinkCnt[k] != 8'd0)
            sinkCnt[k] <= sinkCnt[k] - 8'd1;
         else if (txSend[k] && !txBusy[k] && !sinkDeaf)
            sinkCnt[k] <= sinkLong ? 8'd50 : 8'($urandom_range(1, 4));
      end
   end

   logic [7:0]  expTx [$];
   logic [15:0] expWr [$];
   logic [7:0]  expRd [$];
   int          expErr = 0;
   logic [7:0]  expMem [256];

   int txIdx  [2] = '{default: 0};
   int wrIdx  [2] = '{default: 0};
   int rdIdx  [2] = '{default: 0};
   int errCnt [2] = '{default: 0};
   int checks = 0;
   int errors = 0;

   logic       prevSend [2] = '{default: 1'b0};
   logic       prevBusy [2] = '{default: 1'b0};
   logic [7:0] prevData [2] = '{default: '0};
   logic       prevWr   [2] = '{default: 1'b0};
   logic       prevRd   [2] = '{default: 1'b0};
   logic       prevRst      = 1'b1;

   task automatic fail(input string name, input int k,
                       input logic [15:0] act, input logic [15:0] exp);
      errors++;
      $display("FAIL %s dut%0d: got %h, expected %h", name, k, act, exp);
   endtask

   task automatic check(input string name, input int k,
                        input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) fail(name, k, act, exp);
   endtask

   always @(negedge clk) begin
      if (hang) begin
         checks++;
         fail("done_wait_expired", 0, 16'(txIdx[0]), 16'(expTx.size()));
      end
      for (int k = 0; k < 2; k++) begin
         if (chkZero) begin
            check("reset_ctl", k,
                  {txData[k], 4'b0, txSend[k], wrEn[k], rdEn[k], err[k]},
                  16'h0000);
            check("reset_bus", k, {addr[k], wrData[k]}, 16'h0000);
         end
         if (!rst && !prevRst) begin
            if (txSend[k] && !txBusy[k] && !sinkDeaf) begin
               if (txIdx[k] < expTx.size())
                  check("tx_byte", k, 16'(txData[k]),
                        16'(expTx[txIdx[k]]));
               else begin
                  checks++;
                  fail("tx_extra", k, 16'(txData[k]), 16'(txIdx[k]));
               end
               txIdx[k]++;
            end
            if (prevSend[k] && txSend[k])
               check("tx_stable", k, 16'(txData[k]), 16'(prevData[k]));
            if (prevSend[k] && prevBusy[k])
               check("tx_drop", k, 16'(txSend[k]), 16'd0);
            else if (prevSend[k])
               check("tx_hold", k, 16'(txSend[k]), 16'd1);
            if (!prevSend[k] && txSend[k])
               check("tx_start_busy", k, 16'(prevBusy[k]), 16'd0);
            if (wrEn[k]) begin
               check("wr_pulse", k, 16'(prevWr[k]), 16'd0);
               if (wrIdx[k] < expWr.size())
                  check("wr_bus", k, {addr[k], wrData[k]},
                        expWr[wrIdx[k]]);
               else begin
                  checks++;
                  fail("wr_extra", k, {addr[k], wrData[k]}, 16'hFFFF);
               end
               wrIdx[k]++;
            end
            if (rdEn[k]) begin
               check("rd_pulse", k, 16'(prevRd[k]), 16'd0);
               if (rdIdx[k] < expRd.size())
                  check("rd_addr", k, 16'(addr[k]), 16'(expRd[rdIdx[k]]));
               else begin
                  checks++;
                  fail("rd_extra", k, 16'(addr[k]), 16'hFFFF);
               end
               rdIdx[k]++;
            end
            if (err[k]) errCnt[k]++;
         end
         if (pktEnd) begin
            check("tx_count", k, 16'(txIdx[k]), 16'(expTx.size()));
            check("wr_count", k, 16'(wrIdx[k]), 16'(expWr.size()));
            check("rd_count", k, 16'(rdIdx[k]), 16'(expRd.size()));
            check("err_count", k, 16'(errCnt[k]), 16'(expErr));
         end
         prevSend[k] <= txSend[k];
         prevBusy[k] <= txBusy[k];
         prevData[k] <= txData[k];
         prevWr[k]   <= wrEn[k];
         prevRd[k]   <= rdEn[k];
      end
      prevRst <= rst;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic sendByte(input logic [7:0] b);
      rxData  = b;
      rxValid = 1'b1;
      tick(1);
      rxValid = 1'b0;
   endtask

   task automatic sendGap(input logic [7:0] b);
      sendByte(b);
      tick($urandom_range(0, 2));
   endtask

   task automatic flagHang();
      hang = 1'b1;
      tick(1);
      hang = 1'b0;
   endtask

   task automatic waitTx();
      int n = 0;
      while ((txIdx[0] != expTx.size() || txIdx[1] != expTx.size())
             && n < 3000) begin
         tick(1);
         n++;
      end
      if (n >= 3000) flagHang();
   endtask

   task automatic waitDone();
      int n = 0;
      while ((txIdx[0] != expTx.size() || txIdx[1] != expTx.size()
              || sinkCnt[0] != 8'd0 || sinkCnt[1] != 8'd0)
             && n < 3000) begin
         tick(1);
         n++;
      end
      if (n >= 3000) flagHang();
      tick(3);
   endtask

   task automatic endPkt();
      pktEnd = 1'b1;
      tick(1);
      pktEnd = 1'b0;
   endtask

   task automatic doWrite(input logic [7:0] a, input logic [7:0] d);
      expWr.push_back({a, d});
      expTx.push_back(8'h06);
      expMem[a] = d;
      sendGap(8'h55);
      sendGap(8'h57);
      sendGap(a);
      sendByte(d);
      waitDone();
      endPkt();
   endtask

   task automatic doRead(input logic [7:0] a);
      expRd.push_back(a);
      expTx.push_back(8'h06);
      expTx.push_back(expMem[a]);
      sendGap(8'h55);
      sendGap(8'h52);
      sendByte(a);
      waitDone();
      endPkt();
   endtask

   initial begin
      logic [7:0] a, d, b;
      for (int i = 0; i < 256; i++) expMem[i] = 8'h00;
      tick(3);
      rst = 1'b0;
      chkZero = 1'b1;
      tick(1);
      chkZero = 1'b0;

      // write then read back, literal expectations
      expWr.push_back(16'h3CA5);
      expTx.push_back(8'h06);
      expMem[8'h3C] = 8'hA5;
      sendByte(8'h55); sendByte(8'h57); sendByte(8'h3C); sendByte(8'hA5);
      waitDone(); endPkt();
      expRd.push_back(8'h3C);
      expTx.push_back(8'h06);
      expTx.push_back(8'hA5);
      sendByte(8'h55); sendByte(8'h52); sendByte(8'h3C);
      waitDone(); endPkt();

      // leading garbage is ignored
      expRd.push_back(8'h10);
      expTx.push_back(8'h06);
      expTx.push_back(8'h00);
      sendByte(8'h00); sendByte(8'hFF);
      sendByte(8'h55); sendByte(8'h52); sendByte(8'h10);
      waitDone(); endPkt();

      // unknown command
      expTx.push_back(8'h15);
      expErr++;
      sendByte(8'h55); sendByte(8'h41);
      waitDone(); endPkt();

      // inter-byte timeout, then a clean write
      sendByte(8'h55); sendByte(8'h57); sendByte(8'h20);
      tick(TOUT + 10);
      expErr++;
      endPkt();
      doWrite(8'h20, 8'h7E);

      // long busy before ACK, late accept, Rx byte during TX_DATA
      forceBusy = 1'b1;
      expRd.push_back(8'h3C);
      expTx.push_back(8'h06);
      expTx.push_back(8'hA5);
      sendByte(8'h55); sendByte(8'h52); sendByte(8'h3C);
      tick(1000);
      sinkDeaf  = 1'b1;
      forceBusy = 1'b0;
      tick(20);
      sinkLong = 1'b1;
      sinkDeaf = 1'b0;
      waitTx();
      tick(5);
      sendByte(8'h77);
      expErr++;
      sinkLong = 1'b0;
      waitDone(); endPkt();

      // reset mid-packet aborts the write
      sendByte(8'h55); sendByte(8'h57); sendByte(8'h01);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chkZero = 1'b1;
      tick(1);
      chkZero = 1'b0;
      sendByte(8'h09);
      tick(10);
      endPkt();

      // random packets against the register-file model
      for (int n = 0; n < 1000; n++) begin
         a = 8'($urandom_range(0, 15));
         d = 8'($urandom);
         b = 8'($urandom);
         if (b != 8'h55 && $urandom_range(0, 7) == 0) sendGap(b);
         if ($urandom_range(0, 1) == 1) doWrite(a, d);
         else doRead(a);
      end

      tick(5);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
